// File: rtl/carry_save_adder.sv
// carry_save_adder
//   Adds four unsigned WIDTH-bit operands, a + b + c + d. The sum passes
//   through two pipeline register stages, so it appears two clocks after the
//   operands.
//
//   The datapath is:
//     1. a 3:2 carry-save level on a, b and c,
//     2. a second 3:2 carry-save level that folds in d,
//     3. a ripple carry-propagate adder.
//
//   {cout, sum} is the exact WIDTH+2-bit total. 4*(2^WIDTH-1) always fits in
//   that width, so no result bits are lost.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; clears every pipeline register
//   in_valid   a..d carry a valid operand set this cycle
//   a,b,c,d    unsigned operands, WIDTH bits each
//   sum        low WIDTH+1 bits of the total (registered)
//   cout       MSB (bit WIDTH+1) of the total (registered)
//   out_valid  in_valid delayed by two clocks (registered)

module carry_save_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   sum,
  output logic             cout,
  output logic             out_valid
);

  // Stage 1: first CSA level.
  // Each bit is an independent full adder, so no carry ripples between bits.
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] k1;

  assign s1 = a ^ b ^ c;
  assign k1 = (a & b) | (a & c) | (b & c);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] k1_q;
  logic [WIDTH-1:0] d_q;
  logic             v1_q;

  // Data registers load every cycle. in_valid only travels alongside the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      k1_q <= '0;
      d_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= s1;
      k1_q <= k1;
      d_q  <= d;
      v1_q <= in_valid;
    end
  end

  // Stage 2: second CSA level.
  // k1 has weight 2, so it enters shifted left by one bit.
  logic [WIDTH:0] x2;
  logic [WIDTH:0] y2;
  logic [WIDTH:0] z2;
  logic [WIDTH:0] s2;
  logic [WIDTH:0] k2;

  assign x2 = {1'b0, s1_q};
  assign y2 = {k1_q, 1'b0};
  assign z2 = {1'b0, d_q};
  assign s2 = x2 ^ y2 ^ z2;
  assign k2 = (x2 & y2) | (x2 & z2) | (y2 & z2);

  // Ripple carry-propagate adder: s2 + (k2 << 1), WIDTH+2 bits wide.
  // The carry out of the top bit is always zero, because the total is bounded
  // by 4*(2^WIDTH-1). It is therefore not kept.
  logic [WIDTH+1:0] cpa_p;
  logic [WIDTH+1:0] cpa_q;
  logic [WIDTH+1:0] total;
  logic             carry;

  assign cpa_p = {1'b0, s2};
  assign cpa_q = {k2, 1'b0};

  always_comb begin
    total = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      total[i] = cpa_p[i] ^ cpa_q[i] ^ carry;
      carry    = (cpa_p[i] & cpa_q[i]) | (cpa_p[i] & carry) | (cpa_q[i] & carry);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= total[WIDTH:0];
      cout      <= total[WIDTH+1];
      out_valid <= v1_q;
    end
  end

endmodule

// File: tb/tb_carry_save_adder.sv
// Testbench for carry_save_adder at WIDTH=4.
//
// Each step drives one operand set and advances one clock. Every expected
// total is computed here from the truncated operands and queued as the
// stimulus is driven. A queued entry is popped and compared one clock after
// it was sampled, which is when it emerges after the two register stages.
// A reset edge empties the queue. Until two entries are queued again, the
// outputs must read as all zeros.

module tb_carry_save_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic [4:0] sum;
  logic       cout;
  logic       out_valid;

  typedef struct packed {
    logic       v;
    logic [5:0] tot;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  carry_save_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set, clock once, then check the outputs 1 ns after
  // the edge.
  task automatic step(input string tag, input logic rst, input logic v,
                      input int av, input int bv, input int cv, input int dv);
    exp_t       e;
    logic [6:0] got;
    logic [6:0] want;
    logic [5:0] t;
    rst_n    = rst;
    in_valid = v;
    a        = av[3:0];
    b        = bv[3:0];
    c        = cv[3:0];
    d        = dv[3:0];
    t = 6'(av & 15) + 6'(bv & 15) + 6'(cv & 15) + 6'(dv & 15);
    @(posedge clk);
    #1;
    if (!rst) sb.delete();
    else      sb.push_back('{v: v, tot: t});
    if (sb.size() >= 2) e = sb.pop_front();
    else                e = '{v: 1'b0, tot: 6'd0};
    got  = {out_valid, cout, sum};
    want = {e.v, e.tot};
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed valid/cout/sum=%b/%b/%0d expected %b/%b/%0d",
             tag, got[6], got[5], got[4:0], want[6], want[5], want[4:0]);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  int va[8] = '{10, 10,  4, 11, 12,  7, 15, 20};
  int vb[8] = '{ 0, 10,  6,  2,  5,  6, 15,  0};
  int vc[8] = '{ 0,  0, 12,  4, 10, 12, 15, 20};
  int vd[8] = '{ 0,  0,  0,  7, 10,  8, 15,  0};

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held for two cycles with random inputs
    for (int i = 0; i < 2; i++)
      step("reset", 1'b0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    idle("post_reset_idle", 3);

    // Directed vectors, one at a time, with idle cycles between them
    for (int i = 0; i < 8; i++) begin
      step($sformatf("directed_%0d", i), 1'b1, 1'b1, va[i], vb[i], vc[i], vd[i]);
      idle($sformatf("directed_%0d_drain", i), 2);
    end

    // The same vectors back to back
    for (int i = 0; i < 8; i++)
      step($sformatf("stream_%0d", i), 1'b1, 1'b1, va[i], vb[i], vc[i], vd[i]);
    idle("stream_drain", 2);

    // Reset with results in flight, then resume streaming
    step("pre_rst_0", 1'b1, 1'b1, va[6], vb[6], vc[6], vd[6]);
    step("pre_rst_1", 1'b1, 1'b1, va[4], vb[4], vc[4], vd[4]);
    step("mid_reset", 1'b0, 1'b1, 15, 15, 15, 15);
    for (int i = 0; i < 8; i++)
      step($sformatf("resume_%0d", i), 1'b1, 1'b1, va[i], vb[i], vc[i], vd[i]);
    idle("resume_drain", 2);

    // Randomized vectors with random in_valid
    for (int i = 0; i < 1200; i++)
      step("random", 1'b1, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    idle("random_drain", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
